// File: rtl/ico_uart_rx_if.sv
// rtl/ico_uart_rx_if.sv - CPU-side read/status bus of the ico UART receiver
//
// Ports (interface signals):
//   rd_strobe  master->slave  one-cycle pulse popping the FIFO head
//   clr_err    master->slave  one-cycle pulse clearing the sticky flags
//   rd_data    slave->master  FIFO head byte, valid while rd_valid=1
//   rd_valid   slave->master  FIFO non-empty
//   count      slave->master  FIFO occupancy, 0..DEPTH
//   overrun    slave->master  sticky: byte dropped on a full FIFO
//   frame_err  slave->master  sticky: stop bit sampled as 0
interface ico_uart_rx_if #(
    parameter int DEPTH = 16
) ();
    logic                     rd_strobe;
    logic                     clr_err;
    logic [7:0]               rd_data;
    logic                     rd_valid;
    logic [$clog2(DEPTH):0]   count;
    logic                     overrun;
    logic                     frame_err;

    modport master (
        output rd_strobe,
        output clr_err,
        input  rd_data,
        input  rd_valid,
        input  count,
        input  overrun,
        input  frame_err
    );

    modport slave (
        input  rd_strobe,
        input  clr_err,
        output rd_data,
        output rd_valid,
        output count,
        output overrun,
        output frame_err
    );
endinterface

// File: rtl/ico_uart_rx.sv
// rtl/ico_uart_rx.sv - 8N1 UART receiver with byte FIFO and cts_n flow control
//
// Ports:
//   clk_core  core clock, all logic on its rising edge
//   reset     synchronous active-high reset
//   rx        raw asynchronous RX pin, idle high
//   cts_n     registered active-low clear-to-send
//   bus       read/status bus (slave side of ico_uart_rx_if)
module ico_uart_rx #(
    parameter int CYCLES_PER_BIT = 87,
    parameter int DEPTH          = 16,
    parameter int CTS_SLACK      = 4
) (
    input  logic           clk_core,
    input  logic           reset,
    input  logic           rx,
    output logic           cts_n,
    ico_uart_rx_if.slave   bus
);
    localparam int CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0]    FULL       = CW'(DEPTH);
    localparam logic [CW-1:0]    CTS_THRESH = CW'(DEPTH - CTS_SLACK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t            state;
    logic              rx_meta;
    logic              rx_s;
    logic [CNT_W-1:0]  bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              push_req;
    logic [7:0]        push_data;
    logic              frame_err;

    logic [7:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              overrun;
    logic              pop;
    logic              push_ok;

    wire sample = (bit_cnt == '0);

    // Receive FSM. The completed byte is handed to the FIFO through the
    // push_req/push_data register, so the FIFO sees it one edge later.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= S_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            push_req  <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            push_req <= 1'b0;
            if (bus.clr_err)
                frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        bit_cnt <= HALF_LOAD;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (!sample) begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else if (rx_s) begin
                        state <= S_IDLE;
                    end else begin
                        bit_cnt <= BIT_LOAD;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!sample) begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= BIT_LOAD;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (!sample) begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else if (rx_s) begin
                        push_req  <= 1'b1;
                        push_data <= shift;
                        state     <= S_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    // A held-low line (break) must return high before a new
                    // start bit can be recognised.
                    if (rx_s)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A push into a full FIFO is still accepted if the head leaves this cycle.
    assign pop     = bus.rd_strobe && (count != '0);
    assign push_ok = push_req && ((count != FULL) || pop);

    always_comb begin
        count_next = count;
        if (push_ok && !pop)
            count_next = count + CW'(1);
        else if (!push_ok && pop)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk_core) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            cts_n   <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            if (bus.clr_err)
                overrun <= 1'b0;
            if (push_req && !push_ok)
                overrun <= 1'b1;
            cts_n <= (count_next >= CTS_THRESH);
        end
    end

    assign bus.rd_data   = mem[rd_ptr];
    assign bus.rd_valid  = (count != '0);
    assign bus.count     = count;
    assign bus.overrun   = overrun;
    assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_ico_uart_rx.sv
// tb/tb_ico_uart_rx.sv - directed testbench for ico_uart_rx
module tb_ico_uart_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic cts_n;
    int   vectors = 0;
    int   miscompares = 0;

    ico_uart_rx_if #(.DEPTH(16)) bus ();

    ico_uart_rx #(
        .CYCLES_PER_BIT (8),
        .DEPTH          (16),
        .CTS_SLACK      (4)
    ) dut (
        .clk_core (clk),
        .reset    (reset),
        .rx       (rx),
        .cts_n    (cts_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Drives one 8N1 frame; returns #1 after the edge that samples the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk); #1 rx = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat (8) @(posedge clk);
            #1 rx = b[k];
        end
        repeat (8) @(posedge clk);
        #1 rx = stop;
        repeat (7) @(posedge clk);
        #1;
    endtask

    // Frame plus one cycle so the FIFO has taken the byte.
    task automatic send_push(input logic [7:0] b);
        send_byte(b, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic pop_one();
        bus.rd_strobe = 1'b1;
        @(posedge clk); #1 bus.rd_strobe = 1'b0;
    endtask

    task automatic clear_err();
        bus.clr_err = 1'b1;
        @(posedge clk); #1 bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fifo count=%0d rd_valid=%b want 0/0", bus.count, bus.rd_valid);
        end
        vectors++;
        if (bus.overrun !== 1'b0 || bus.frame_err !== 1'b0 || cts_n !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_flags ovr=%b fe=%b cts_n=%b want 0/0/1", bus.overrun, bus.frame_err, cts_n);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (cts_n !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_cts got %b want 0", cts_n);
        end
    endtask

    task automatic test_empty_pop();
        pop_one();
        vectors++;
        if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_pop count=%0d rd_valid=%b want 0/0", bus.count, bus.rd_valid);
        end
    endtask

    task automatic test_basic();
        send_byte(8'hA5, 1'b1);
        vectors++;
        if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early count=%0d rd_valid=%b want 0/0", bus.count, bus.rd_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.count !== 5'd1 || bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic_push count=%0d rd_valid=%b data=%h want 1/1/a5", bus.count, bus.rd_valid, bus.rd_data);
        end
        pop_one();
        vectors++;
        if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pop count=%0d rd_valid=%b ovr=%b fe=%b want 0/0/0/0", bus.count, bus.rd_valid, bus.overrun, bus.frame_err);
        end
    endtask

    task automatic test_glitch();
        @(posedge clk); #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        vectors++;
        if (bus.count !== 5'd0 || bus.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_reject count=%0d fe=%b want 0/0", bus.count, bus.frame_err);
        end
        send_push(8'h55);
        vectors++;
        if (bus.count !== 5'd1 || bus.rd_data !== 8'h55) begin
            miscompares++;
            $display("FAIL glitch_next count=%0d data=%h want 1/55", bus.count, bus.rd_data);
        end
        pop_one();
    endtask

    task automatic test_frame_break();
        send_byte(8'h3C, 1'b0);
        vectors++;
        if (bus.frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_err_set got %b want 1", bus.frame_err);
        end
        repeat (160) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (bus.count !== 5'd0) begin
            miscompares++;
            $display("FAIL frame_no_push count=%0d want 0", bus.count);
        end
        send_push(8'h81);
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (bus.count !== 5'd1 || bus.rd_data !== 8'h81 || bus.frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_after_break count=%0d data=%h fe=%b want 1/81/1", bus.count, bus.rd_data, bus.frame_err);
        end
        pop_one();
        clear_err();
        vectors++;
        if (bus.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_clr got %b want 0", bus.frame_err);
        end
    endtask

    task automatic test_overrun_cts();
        int exp_cnt;
        for (int i = 0; i <= 16; i++) begin
            send_push(8'(i));
            exp_cnt = (i + 1 > 16) ? 16 : i + 1;
            vectors++;
            if (bus.count !== 5'(exp_cnt) || cts_n !== (exp_cnt >= 12) || bus.overrun !== (i == 16)) begin
                miscompares++;
                $display("FAIL fill_%0d count=%0d cts_n=%b ovr=%b want %0d/%b/%b", i, bus.count, cts_n, bus.overrun, exp_cnt, (exp_cnt >= 12), (i == 16));
            end
        end
        for (int j = 0; j < 16; j++) begin
            vectors++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(j)) begin
                miscompares++;
                $display("FAIL drain_data_%0d data=%h valid=%b want %h/1", j, bus.rd_data, bus.rd_valid, 8'(j));
            end
            pop_one();
            exp_cnt = 15 - j;
            vectors++;
            if (bus.count !== 5'(exp_cnt) || cts_n !== (exp_cnt >= 12)) begin
                miscompares++;
                $display("FAIL drain_cnt_%0d count=%0d cts_n=%b want %0d/%b", j, bus.count, cts_n, exp_cnt, (exp_cnt >= 12));
            end
        end
        clear_err();
        vectors++;
        if (bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clr got %b want 0", bus.overrun);
        end
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 16; i++)
            send_push(8'h20 + 8'(i));
        send_byte(8'hEE, 1'b1);
        pop_one();
        vectors++;
        if (bus.count !== 5'd16 || bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_push count=%0d ovr=%b want 16/0", bus.count, bus.overrun);
        end
        for (int j = 1; j < 16; j++) begin
            vectors++;
            if (bus.rd_data !== 8'h20 + 8'(j)) begin
                miscompares++;
                $display("FAIL full_order_%0d data=%h want %h", j, bus.rd_data, 8'h20 + 8'(j));
            end
            pop_one();
        end
        vectors++;
        if (bus.count !== 5'd1 || bus.rd_data !== 8'hEE) begin
            miscompares++;
            $display("FAIL full_last count=%0d data=%h want 1/ee", bus.count, bus.rd_data);
        end
        pop_one();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'hF0;
        send_push(8'h11);
        send_push(8'h22);
        @(posedge clk); #1 rx = 1'b0;
        for (int k = 0; k < 5; k++) begin
            repeat (8) @(posedge clk);
            #1 rx = b[k];
        end
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        vectors++;
        if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_flush count=%0d valid=%b ovr=%b fe=%b want 0/0/0/0", bus.count, bus.rd_valid, bus.overrun, bus.frame_err);
        end
        @(posedge clk); #1;
        vectors++;
        if (cts_n !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_cts got %b want 0", cts_n);
        end
        send_push(8'h42);
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (bus.count !== 5'd1 || bus.rd_data !== 8'h42 || bus.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_next count=%0d data=%h fe=%b want 1/42/0", bus.count, bus.rd_data, bus.frame_err);
        end
    endtask

    initial begin
        bus.rd_strobe = 1'b0;
        bus.clr_err   = 1'b0;
        test_reset();
        test_empty_pop();
        test_basic();
        test_glitch();
        test_frame_break();
        test_overrun_cts();
        test_full_pop_push();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
